// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, word address to instruction_memory, IF/ID register.
// Latency 1 cycle PC->out_valid; redirect squashes and costs a 1-cycle bubble; stalls hold while out_ready=0.
// Optional FETCH_MISALIGN_FAULT_EN adds a sticky misaligned-redirect fault that halts fetch.
module instruction_fetch #(
  parameter int                  WORDSIZE         = 64,
  parameter int                  INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
  input  logic                        redirect_valid,
  input  logic [WORDSIZE-1:0]         redirect_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [INSTRUCTION_SIZE-1:0] out_instruction,
  output logic [WORDSIZE-1:0]         out_pc
`ifdef FETCH_MISALIGN_FAULT_EN
  ,
  output logic                        fault
`endif
);

  logic [WORDSIZE-1:0] pc;
  logic                load;
  logic                halted;
  logic                misaligned;
  logic [WORDSIZE-1:0] target_pc;

  assign imem_addr = {2'b00, pc[WORDSIZE-1:2]};
  assign load      = !out_valid || out_ready;

`ifdef FETCH_MISALIGN_FAULT_EN
  assign target_pc  = redirect_pc;
  assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign halted     = fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (misaligned) begin
      fault <= 1'b1;
    end
  end
`else
  // Low address bits are dropped so the PC can never become misaligned.
  assign target_pc  = redirect_pc & ~WORDSIZE'(3);
  assign misaligned = 1'b0;
  assign halted     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc              <= RESET_PC;
      out_valid       <= 1'b0;
      out_instruction <= '0;
      out_pc          <= '0;
    end else if (halted) begin
      // A faulted stage stays frozen until reset, ignoring further redirects.
      out_valid <= 1'b0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
      if (!misaligned) begin
        pc <= target_pc;
      end
    end else if (load) begin
      out_instruction <= imem_instruction;
      out_pc          <= pc;
      out_valid       <= 1'b1;
      pc              <= pc + WORDSIZE'(4);
    end
  end

endmodule
